// File: rtl/toy_bus_mem_initiator.sv
// ---------------------------------------------------------------------------
// toy_bus_mem_initiator
//
// Converts single core-side load/store requests into ToyBusReq transactions
// and returns the matching ToyBusAck of a read to the core as a response.
// Only one transaction is in flight at a time. Writes are posted: they finish
// on the bus request handshake. Reads wait for an ack addressed to NODE_ID,
// or for the optional timeout, which returns zero data with err set.
//
// Parameters
//   NODE_ID  bus id of this node (req src_id, matched against ack tgt_id)
//   TGT_ID   bus id of the target memory slave (req tgt_id)
//   TIMEOUT  cycles to wait for a read ack; 0 waits forever
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   core_req_*           core request channel (vld/rdy, addr, wr, data, strb)
//   core_rsp_*           read response channel (vld/rdy, data, err)
//   out0_req_*           bus request channel, payload driven from registers
//   out0_ack_*           bus ack channel, always ready
//   ack_drop             high in any cycle where an accepted ack is discarded
// ---------------------------------------------------------------------------
module toy_bus_mem_initiator #(
    parameter logic [3:0]  NODE_ID = 4'h1,
    parameter logic [3:0]  TGT_ID  = 4'h0,
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        core_req_vld,
    output logic        core_req_rdy,
    input  logic [31:0] core_req_addr,
    input  logic        core_req_wr,
    input  logic [31:0] core_req_data,
    input  logic [3:0]  core_req_strb,

    output logic        core_rsp_vld,
    input  logic        core_rsp_rdy,
    output logic [31:0] core_rsp_data,
    output logic        core_rsp_err,

    output logic        out0_req_vld,
    input  logic        out0_req_rdy,
    output logic [31:0] out0_req_addr,
    output logic [3:0]  out0_req_strb,
    output logic [31:0] out0_req_data,
    output logic        out0_req_opcode,
    output logic [3:0]  out0_req_src_id,
    output logic [3:0]  out0_req_tgt_id,

    input  logic        out0_ack_vld,
    output logic        out0_ack_rdy,
    input  logic        out0_ack_opcode,
    input  logic [31:0] out0_ack_data,
    input  logic [3:0]  out0_ack_src_id,
    input  logic [3:0]  out0_ack_tgt_id,

    output logic        ack_drop
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        RSP
    } state_t;

    state_t state;
    state_t state_nxt;

    // Request and response registers
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_strb;
    logic        req_wr;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [15:0] cnt;

    // Control strobes from the FSM to the datapath
    logic cap_req;
    logic clr_cnt;
    logic cap_ack;
    logic cap_to;

    logic ack_match;
    logic expired;

    // The ack opcode and source id carry nothing this node needs.
    logic unused_ack_fields;
    assign unused_ack_fields = ^{out0_ack_opcode, out0_ack_src_id};

    assign ack_match = out0_ack_vld && (out0_ack_tgt_id == NODE_ID);
    assign expired   = (TIMEOUT != 16'd0) && (cnt == TIMEOUT - 16'd1);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and handshake outputs
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_nxt    = state;
        core_req_rdy = 1'b0;
        out0_req_vld = 1'b0;
        core_rsp_vld = 1'b0;
        cap_req      = 1'b0;
        clr_cnt      = 1'b0;
        cap_ack      = 1'b0;
        cap_to       = 1'b0;

        case (state)
            IDLE: begin
                core_req_rdy = 1'b1;
                if (core_req_vld) begin
                    cap_req   = 1'b1;
                    state_nxt = REQ;
                end
            end

            REQ: begin
                out0_req_vld = 1'b1;
                if (out0_req_rdy) begin
                    if (req_wr) begin
                        state_nxt = IDLE;
                    end else begin
                        clr_cnt   = 1'b1;
                        state_nxt = WAIT_ACK;
                    end
                end
            end

            WAIT_ACK: begin
                // A matching ack in the expiry cycle still counts as success.
                if (ack_match) begin
                    cap_ack   = 1'b1;
                    state_nxt = RSP;
                end else if (expired) begin
                    cap_to    = 1'b1;
                    state_nxt = RSP;
                end
            end

            RSP: begin
                core_rsp_vld = 1'b1;
                if (core_rsp_rdy) begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_addr <= 32'h0;
            req_data <= 32'h0;
            req_strb <= 4'h0;
            req_wr   <= 1'b0;
            rsp_data <= 32'h0;
            rsp_err  <= 1'b0;
            cnt      <= 16'h0;
        end else begin
            if (cap_req) begin
                req_addr <= core_req_addr;
                req_data <= core_req_data;
                req_strb <= core_req_strb;
                req_wr   <= core_req_wr;
            end

            // Saturating wait counter: it stops at all-ones instead of
            // wrapping, so a huge TIMEOUT can never be skipped over.
            if (clr_cnt) begin
                cnt <= 16'h0;
            end else if (state == WAIT_ACK && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end

            if (cap_ack) begin
                rsp_data <= out0_ack_data;
                rsp_err  <= 1'b0;
            end else if (cap_to) begin
                rsp_data <= 32'h0;
                rsp_err  <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output assignments
    // ---------------------------------------------------------------------
    assign out0_req_addr   = req_addr;
    assign out0_req_data   = req_data;
    assign out0_req_strb   = req_strb;
    assign out0_req_opcode = req_wr;
    assign out0_req_src_id = NODE_ID;
    assign out0_req_tgt_id = TGT_ID;

    assign core_rsp_data   = rsp_data;
    assign core_rsp_err    = rsp_err;

    // The ack channel never back-pressures, so every valid ack is accepted;
    // anything not consumed by WAIT_ACK is discarded, including late acks.
    assign out0_ack_rdy    = 1'b1;
    assign ack_drop        = out0_ack_vld && ((state != WAIT_ACK) || (out0_ack_tgt_id != NODE_ID));

endmodule

// File: tb/tb_toy_bus_mem_initiator.sv
// ---------------------------------------------------------------------------
// tb_toy_bus_mem_initiator
//
// Drives directed and randomized read/write transactions through the
// initiator. The bench plays the memory slave with a small word array and
// predicts each read result from transaction-level rules: ack data unless the
// ack arrives TIMEOUT or more cycles into the wait, in which case zero data
// with err set after exactly TIMEOUT wait cycles.
// ---------------------------------------------------------------------------
module tb_toy_bus_mem_initiator;

    localparam logic [3:0] NODE_ID = 4'h1;
    localparam logic [3:0] TGT_ID  = 4'h0;
    localparam int         TMO     = 8;

    logic        clk;
    logic        rst_n;
    logic        core_req_vld;
    logic        core_req_rdy;
    logic [31:0] core_req_addr;
    logic        core_req_wr;
    logic [31:0] core_req_data;
    logic [3:0]  core_req_strb;
    logic        core_rsp_vld;
    logic        core_rsp_rdy;
    logic [31:0] core_rsp_data;
    logic        core_rsp_err;
    logic        out0_req_vld;
    logic        out0_req_rdy;
    logic [31:0] out0_req_addr;
    logic [3:0]  out0_req_strb;
    logic [31:0] out0_req_data;
    logic        out0_req_opcode;
    logic [3:0]  out0_req_src_id;
    logic [3:0]  out0_req_tgt_id;
    logic        out0_ack_vld;
    logic        out0_ack_rdy;
    logic        out0_ack_opcode;
    logic [31:0] out0_ack_data;
    logic [3:0]  out0_ack_src_id;
    logic [3:0]  out0_ack_tgt_id;
    logic        ack_drop;

    int n_checks = 0;
    int n_errors = 0;

    // Slave memory model, word-indexed by addr[5:2]
    logic [31:0] mem [16];

    toy_bus_mem_initiator #(
        .NODE_ID (NODE_ID),
        .TGT_ID  (TGT_ID),
        .TIMEOUT (16'(TMO))
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .core_req_vld    (core_req_vld),
        .core_req_rdy    (core_req_rdy),
        .core_req_addr   (core_req_addr),
        .core_req_wr     (core_req_wr),
        .core_req_data   (core_req_data),
        .core_req_strb   (core_req_strb),
        .core_rsp_vld    (core_rsp_vld),
        .core_rsp_rdy    (core_rsp_rdy),
        .core_rsp_data   (core_rsp_data),
        .core_rsp_err    (core_rsp_err),
        .out0_req_vld    (out0_req_vld),
        .out0_req_rdy    (out0_req_rdy),
        .out0_req_addr   (out0_req_addr),
        .out0_req_strb   (out0_req_strb),
        .out0_req_data   (out0_req_data),
        .out0_req_opcode (out0_req_opcode),
        .out0_req_src_id (out0_req_src_id),
        .out0_req_tgt_id (out0_req_tgt_id),
        .out0_ack_vld    (out0_ack_vld),
        .out0_ack_rdy    (out0_ack_rdy),
        .out0_ack_opcode (out0_ack_opcode),
        .out0_ack_data   (out0_ack_data),
        .out0_ack_src_id (out0_ack_src_id),
        .out0_ack_tgt_id (out0_ack_tgt_id),
        .ack_drop        (ack_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Step past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_core_req_rdy", core_req_rdy, 1);
        check("rst_ack_rdy", out0_ack_rdy, 1);
        check("rst_rsp_vld", core_rsp_vld, 0);
        check("rst_rsp_data", core_rsp_data, 0);
        check("rst_rsp_err", core_rsp_err, 0);
        check("rst_req_vld", out0_req_vld, 0);
        check("rst_req_addr", out0_req_addr, 0);
        check("rst_req_data", out0_req_data, 0);
        check("rst_req_strb", out0_req_strb, 0);
        check("rst_req_opcode", out0_req_opcode, 0);
        check("rst_ack_drop", ack_drop, 0);
    endtask

    // Core side handshake; returns after the edge that accepts the request.
    task automatic core_issue(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic wr);
        core_req_vld  = 1'b1;
        core_req_addr = addr;
        core_req_data = data;
        core_req_strb = strb;
        core_req_wr   = wr;
        check("issue_core_req_rdy", core_req_rdy, 1);
        tick();
        core_req_vld  = 1'b0;
        core_req_addr = $urandom;
        core_req_data = $urandom;
    endtask

    // Bus request phase: stall cycles with rdy low, then the handshake cycle.
    task automatic bus_req_phase(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input logic wr, input int stall);
        for (int s = 0; s <= stall; s++) begin
            out0_req_rdy = (s == stall);
            check("req_vld", out0_req_vld, 1);
            check("req_addr", out0_req_addr, addr);
            check("req_data", out0_req_data, data);
            check("req_strb", out0_req_strb, 32'(strb));
            check("req_opcode", out0_req_opcode, 32'(wr));
            check("req_src_id", out0_req_src_id, 32'(NODE_ID));
            check("req_tgt_id", out0_req_tgt_id, 32'(TGT_ID));
            check("req_core_rdy_low", core_req_rdy, 0);
            tick();
            out0_req_rdy = 1'b0;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int stall);
        logic [3:0] idx;
        core_issue(addr, data, strb, 1'b1);
        bus_req_phase(addr, data, strb, 1'b1, stall);
        check("wr_core_rdy_back", core_req_rdy, 1);
        check("wr_no_rsp", core_rsp_vld, 0);
        check("wr_req_vld_low", out0_req_vld, 0);
        idx = addr[5:2];
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) mem[idx][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    // ack_delay: WAIT_ACK cycle index on which the matching ack is driven.
    // wrong_at:  cycle index of a misrouted ack (tgt 3), -1 for none.
    // hold:      cycles core_rsp_rdy stays low once the response is up.
    // late_ack:  drive a matching ack on the second hold cycle.
    // rst_in_rsp: end the transaction with a reset instead of rsp_rdy.
    task automatic do_read(input logic [31:0] addr, input int stall, input int ack_delay,
                           input int wrong_at, input int hold, input bit late_ack,
                           input bit rst_in_rsp);
        logic [3:0]  idx;
        logic [31:0] exp_data;
        logic [31:0] data;
        logic [3:0]  strb;
        bit          exp_err;
        int          exp_wait;
        int          c;
        bit          done;

        idx      = addr[5:2];
        exp_err  = (ack_delay >= TMO);
        exp_data = exp_err ? 32'h0 : mem[idx];
        exp_wait = exp_err ? TMO : ack_delay + 1;
        data     = $urandom;
        strb     = 4'($urandom);

        core_issue(addr, data, strb, 1'b0);
        bus_req_phase(addr, data, strb, 1'b0, stall);

        c    = 0;
        done = 1'b0;
        while (!done && c < 40) begin
            if (c == ack_delay) begin
                out0_ack_vld    = 1'b1;
                out0_ack_tgt_id = NODE_ID;
                out0_ack_data   = mem[idx];
                out0_ack_src_id = TGT_ID;
            end else if (c == wrong_at) begin
                out0_ack_vld    = 1'b1;
                out0_ack_tgt_id = 4'h3;
                out0_ack_data   = $urandom;
            end
            #1;
            check("wait_ack_drop", ack_drop, 32'(c == wrong_at && c != ack_delay));
            check("wait_no_rsp", core_rsp_vld, 0);
            tick();
            out0_ack_vld = 1'b0;
            c++;
            done = core_rsp_vld;
        end
        check("rd_wait_cycles", c, exp_wait);

        for (int h = 0; h < hold; h++) begin
            if (late_ack && h == 1) begin
                out0_ack_vld    = 1'b1;
                out0_ack_tgt_id = NODE_ID;
                out0_ack_data   = $urandom;
            end
            #1;
            check("rsp_hold_ack_drop", ack_drop, 32'(late_ack && h == 1));
            check("rsp_hold_vld", core_rsp_vld, 1);
            check("rsp_hold_data", core_rsp_data, exp_data);
            check("rsp_hold_err", core_rsp_err, 32'(exp_err));
            tick();
            out0_ack_vld = 1'b0;
        end

        if (rst_in_rsp) begin
            rst_n = 1'b0;
            tick();
            check_reset_outputs();
            rst_n = 1'b1;
            return;
        end

        core_rsp_rdy = 1'b1;
        check("rsp_vld", core_rsp_vld, 1);
        check("rsp_data", core_rsp_data, exp_data);
        check("rsp_err", core_rsp_err, 32'(exp_err));
        tick();
        core_rsp_rdy = 1'b0;
        check("rsp_done_vld_low", core_rsp_vld, 0);
        check("rsp_done_core_rdy", core_req_rdy, 1);
        tick();
        check("rsp_no_second", core_rsp_vld, 0);
    endtask

    initial begin
        rst_n           = 1'b0;
        core_req_vld    = 1'b0;
        core_req_addr   = 32'h0;
        core_req_wr     = 1'b0;
        core_req_data   = 32'h0;
        core_req_strb   = 4'h0;
        core_rsp_rdy    = 1'b0;
        out0_req_rdy    = 1'b0;
        out0_ack_vld    = 1'b0;
        out0_ack_opcode = 1'b0;
        out0_ack_data   = 32'h0;
        out0_ack_src_id = 4'h0;
        out0_ack_tgt_id = 4'h0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        tick();
        tick();
        check_reset_outputs();
        rst_n = 1'b1;
        tick();

        // Zero-wait read: response three cycles after the core handshake
        mem[4] = 32'hCAFE_0001;
        do_read(32'h0000_0010, 0, 0, -1, 0, 1'b0, 1'b0);

        // Write held off by the bus for three cycles
        do_write(32'h0000_0020, 32'hA5A5_A5A5, 4'b0011, 3);

        // Read with no ack: timeout response, then a late ack is dropped
        do_read(32'h0000_0030, 0, 100, -1, 3, 1'b1, 1'b0);

        // Misrouted ack is dropped, the following matching ack completes
        do_read(32'h0000_0014, 1, 4, 1, 0, 1'b0, 1'b0);

        // Matching ack on the last cycle before expiry wins over the timeout
        do_read(32'h0000_0018, 0, TMO - 1, -1, 1, 1'b0, 1'b0);

        // Response held for five cycles, then aborted by reset
        do_read(32'h0000_001C, 0, 2, -1, 5, 1'b0, 1'b1);
        tick();

        // Read back the partially written word
        do_read(32'h0000_0020, 0, 1, -1, 0, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] addr;
            int          stall;
            int          dly;
            int          wrong;
            addr  = {26'($urandom), 2'b00} & 32'h0000_003C;
            stall = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) begin
                do_write(addr, $urandom, 4'($urandom), stall);
            end else begin
                dly   = $urandom_range(0, TMO + 2);
                wrong = -1;
                if (dly > 0 && dly < TMO && $urandom_range(0, 1) == 1)
                    wrong = $urandom_range(0, dly - 1);
                do_read(addr, stall, dly, wrong, $urandom_range(0, 3),
                        1'b0, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/toy_bus_mem_initiator.md
# toy_bus_mem_initiator

Bus-side initiator that accepts single load/store requests from a core-side memory port and converts them into ToyBusReq transactions. It collects the matching ToyBusAck for reads and returns it to the core as a response. It sits between a core LSU/fetch port and the toy_bus network, and is the requesting end of the memory-slave endpoint nodes. One transaction is outstanding at a time. Writes are posted; reads are tracked with a timeout.

## Interface
- NODE_ID, 4'h1, this node's bus id; driven on req_src_id and matched against ack_tgt_id
- TGT_ID, 4'h0, bus id of the target memory slave; driven on req_tgt_id
- TIMEOUT, 16'd1024, cycles to wait for a read ack; 0 disables the timeout
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- core_req_vld  in  1  core request valid
- core_req_rdy  out  1  core request ready
- core_req_addr  in  32  byte address
- core_req_wr  in  1  1 = write, 0 = read
- core_req_data  in  32  write data
- core_req_strb  in  4  write byte enables
- core_rsp_vld  out  1  read response valid
- core_rsp_rdy  in  1  read response ready
- core_rsp_data  out  32  read data
- core_rsp_err  out  1  response produced by timeout
- out0_req_vld / out0_req_rdy  out / in  1  bus request handshake
- out0_req_addr  out  32  registered core_req_addr
- out0_req_strb  out  4  registered strb
- out0_req_data  out  32  registered data
- out0_req_opcode  out  1  registered core_req_wr
- out0_req_src_id  out  4  NODE_ID
- out0_req_tgt_id  out  4  TGT_ID
- out0_ack_vld / out0_ack_rdy  in / out  1  bus ack handshake
- out0_ack_opcode  in  1  ignored
- out0_ack_data  in  32  read data
- out0_ack_src_id  in  4  ignored
- out0_ack_tgt_id  in  4  destination id of the ack
- ack_drop  out  1  one-cycle pulse when an ack is discarded

## Operation
- FSM has four states: IDLE, REQ, WAIT_ACK, RSP.
- IDLE:
  - core_req_rdy = 1.
  - When core_req_vld is high, capture addr/data/strb/wr into request registers and go to REQ.
- REQ:
  - out0_req_vld = 1, with the payload taken from the registers.
  - On out0_req_rdy: a write returns to IDLE and produces no core response. A read goes to WAIT_ACK and clears the timeout counter.
- WAIT_ACK:
  - The counter increments each cycle.
  - An ack matches when out0_ack_vld = 1 and out0_ack_tgt_id == NODE_ID.
  - On a matching ack, capture out0_ack_data into the rsp register, set err = 0, and go to RSP.
  - If TIMEOUT != 0 and the counter == TIMEOUT-1 with no matching ack, set rsp data = 32'h0, set err = 1, and go to RSP.
  - If a matching ack and expiry occur in the same cycle, the ack wins (err = 0).
- RSP:
  - core_rsp_vld = 1.
  - On core_rsp_rdy, go to IDLE.
- out0_ack_rdy = 1 in every state, so the bus never stalls.
- An ack is dropped, and ack_drop pulses, when it is accepted outside WAIT_ACK, or when its tgt_id != NODE_ID. This covers late acks after a timeout.
- The counter is 16 bits and saturates; it never wraps.

## Timing
- Reset (rst_n sampled low at a clk edge):
  - State goes to IDLE.
  - All outputs are 0 except core_req_rdy = 1 and out0_ack_rdy = 1, which are driven high in IDLE.
  - core_rsp_data, core_rsp_err, out0_req_* payload and the counter are all 0.
- Reset mid-transaction aborts the transaction. No response is issued and no req_vld is held.
- Read latency with a zero-wait slave (req_rdy = 1, ack one cycle after the handshake):
  - core handshake at cycle T
  - out0_req_vld at T+1
  - ack at T+2
  - core_rsp_vld at T+3
- Write with req_rdy = 1: out0_req_vld at T+1, and core_req_rdy is high again at T+2.
- out0_req_vld, once asserted, stays high with a stable payload until out0_req_rdy.
- core_rsp_vld, once asserted, stays high with stable data/err until core_rsp_rdy.
- Back-to-back throughput is at most one read per 4 cycles and one write per 2 cycles.

## Test plan
- Read, zero-wait slave returning ack_data = 32'hCAFE_0001 with tgt_id = NODE_ID:
  - core reads addr 32'h0000_0010; out0_req_addr = 32'h10, opcode = 0, src_id = 1.
  - core_rsp_vld at T+3 with data = 32'hCAFE_0001 and err = 0.
- Write of addr 32'h20, data 32'hA5A5_A5A5, strb 4'b0011, with req_rdy held low for 3 cycles:
  - req_vld and payload stay stable for 4 cycles and opcode = 1.
  - No core_rsp_vld; core_req_rdy returns the cycle after the handshake.
- Read with no ack and TIMEOUT = 8:
  - core_rsp_vld with err = 1 and data = 0 follows 8 cycles in WAIT_ACK.
  - An ack injected 2 cycles later produces an ack_drop pulse and no second response.
- Ack with tgt_id = 4'h3 during WAIT_ACK:
  - ack_drop pulses and the block stays in WAIT_ACK.
  - A subsequent ack with tgt_id = 1 completes the read normally.
- Matching ack in exactly the expiry cycle (TIMEOUT = 4, ack on the 4th WAIT_ACK cycle) produces err = 0 with the ack's data.
- core_rsp_rdy held low for 5 cycles, then rst_n pulsed low for 1 cycle:
  - rsp_vld/data stay stable until the reset.
  - After reset all outputs are at their reset values and core_req_rdy = 1.
